dlx_data_mem_responder: RTL

//   Responder (memory-side) end of the DLX processor data-memory port. Accepts read/write

---
 rtl/dlx_mem_pkg.sv | 24 ++
 rtl/dlx_data_mem_responder_if.sv | 24 ++
 rtl/dlx_sp_ram.sv | 29 ++
 rtl/dlx_data_mem_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX data-memory responder: FSM states, word geometry
// and the request address checker.
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned BYTE_OFS_BITS = 2;

    // Address is passed zero-extended to 64 bits so one helper serves any ADDR_WIDTH.
    function automatic logic addr_check_error(input logic [63:0] addr,
                                              input int unsigned depth_log2,
                                              input logic        rd_en,
                                              input logic        wr_en);
        logic [63:0] upper;
        upper = addr >> (depth_log2 + BYTE_OFS_BITS);
        return (addr[BYTE_OFS_BITS-1:0] != '0) || (upper != '0) || (rd_en && wr_en);
    endfunction

endpackage

// File: rtl/dlx_data_mem_responder_if.sv
// Data-memory port between the DLX MEMORY ACCESS stage (master) and the responder (slave).
interface dlx_data_mem_responder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  data_rd_en_in;
    logic                  data_wr_en_in;
    logic [ADDR_WIDTH-1:0] data_addr_in;
    logic [DATA_WIDTH-1:0] data_write_in;
    logic [DATA_WIDTH-1:0] data_read_out;
    logic                  resp_valid_out;
    logic                  stall_out;
    logic                  addr_error_out;

    modport master (
        output data_rd_en_in, data_wr_en_in, data_addr_in, data_write_in,
        input  data_read_out, resp_valid_out, stall_out, addr_error_out
    );

    modport slave (
        input  data_rd_en_in, data_wr_en_in, data_addr_in, data_write_in,
        output data_read_out, resp_valid_out, stall_out, addr_error_out
    );
endinterface

// File: rtl/dlx_sp_ram.sv
// Synchronous single-port RAM with write enable and a read register that only
// updates when a read is requested, so it doubles as the read hold register.
module dlx_sp_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the array and its read register are deliberately left out of reset so
    // the array maps onto block RAM; contents survive a reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dlx_data_mem_responder.sv
// Memory-side responder for the DLX data port: checks and accepts requests, waits a
// fixed number of cycles, then pulses resp_valid_out while stalling the pipeline.
module dlx_data_mem_responder
    import dlx_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned WAIT_STATES    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    dlx_data_mem_responder_if.slave  bus
);
    localparam bit         HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    is_read_q, is_read_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    addr_err_q, addr_err_d;
    logic [DATA_WIDTH-1:0]   data_read_q, data_read_d;

    logic                      req;
    logic                      req_err;
    logic                      accept;
    logic [MEM_DEPTH_LOG2-1:0] word_idx;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    assign req      = bus.data_rd_en_in | bus.data_wr_en_in;
    assign req_err  = addr_check_error(64'(bus.data_addr_in), MEM_DEPTH_LOG2,
                                       bus.data_rd_en_in, bus.data_wr_en_in);
    assign accept   = (state_q == ST_IDLE) && req && !req_err;
    assign word_idx = bus.data_addr_in[MEM_DEPTH_LOG2+BYTE_OFS_BITS-1:BYTE_OFS_BITS];

    dlx_sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (accept && bus.data_wr_en_in),
        .re_i    (accept && bus.data_rd_en_in),
        .addr_i  (word_idx),
        .wdata_i (bus.data_write_in),
        .rdata_o (ram_rdata)
    );

    // NOTE: every variable gets its default before the case so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_read_d    = is_read_q;
        data_read_d  = data_read_q;
        addr_err_d   = (state_q == ST_IDLE) && req && req_err;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    is_read_d = bus.data_rd_en_in;
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (is_read_q) begin
                    data_read_d = ram_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        resp_valid_d = (state_d == ST_RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            is_read_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            data_read_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_read_q    <= is_read_d;
            resp_valid_q <= resp_valid_d;
            addr_err_q   <= addr_err_d;
            data_read_q  <= data_read_d;
        end
    end

    // Read data comes straight from the RAM read register during a read response so
    // the zero-wait configuration needs no extra cycle; otherwise the last value holds.
    assign bus.data_read_out  = (state_q == ST_RESP && is_read_q) ? ram_rdata : data_read_q;
    assign bus.resp_valid_out = resp_valid_q;
    assign bus.addr_error_out = addr_err_q;
    assign bus.stall_out      = (state_q == ST_WAIT) ||
                                (HAS_WAIT && (state_q == ST_IDLE) && req && !req_err);
endmodule
